// File: rtl/axis_read_addr.sv
// axis_read_addr
//   Read-job front end for an AXI4 read address channel. A job (byte start
//   address, length in DATA_WIDTH words) is taken over the cfg handshake.
//   The word count is forwarded once to the read-data stage over the len
//   handshake. The job is then split into INCR bursts on the AR channel.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cfg_address/length/val/rdy  job input handshake
//   len_length/val/rdy          word count to the read-data stage
//   axi_ar*                     AXI4 read address channel (master side)
//
// Build option
//   AXIS_READ_ADDR_4K_SPLIT_EN  when defined, no burst crosses a 4 KB
//                               boundary; otherwise the caller guarantees
//                               alignment.
module axis_read_addr #(
    parameter int unsigned CFG_DWIDTH     = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 256,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BURST_MAX      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CFG_DWIDTH-1:0]     cfg_address,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_val,
    output logic                      cfg_rdy,
    output logic [CFG_DWIDTH-1:0]     len_length,
    output logic                      len_val,
    input  logic                      len_rdy,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]                axi_arlen,
    output logic [2:0]                axi_arsize,
    output logic [1:0]                axi_arburst,
    output logic                      axi_arvalid,
    input  logic                      axi_arready
);

    localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned WPB        = AXI_DATA_WIDTH / DATA_WIDTH;
    localparam int unsigned WPB_SHIFT  = $clog2(WPB);
    localparam int unsigned BW         = CFG_DWIDTH + 1;

    // S_DONE is the single busy cycle taken by a zero-length job.
    typedef enum logic [2:0] {
        S_IDLE,
        S_DONE,
        S_LEN,
        S_CALC,
        S_ADDR
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BW-1:0]             beats_q, beats_d;
    logic [8:0]                burst_q, burst_d;
    logic                      cfg_rdy_q, cfg_rdy_d;
    logic                      len_val_q, len_val_d;
    logic [CFG_DWIDTH-1:0]     len_length_q, len_length_d;
    logic                      arvalid_q, arvalid_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                arlen_q, arlen_d;

    logic [BW-1:0]             job_beats;
    logic [AXI_ADDR_WIDTH-1:0] job_addr;
    logic [8:0]                burst_calc;
`ifdef AXIS_READ_ADDR_4K_SPLIT_EN
    logic [12:0]               room_beats;
`endif

    // Beat count is computed one bit wider than cfg_length so that the
    // rounding-up add cannot overflow.
    always_comb begin
        job_beats = ({1'b0, cfg_length} + BW'(WPB - 1)) >> WPB_SHIFT;
        job_addr  = AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);
    end

    // Size of the next burst from the registered address/remaining beats.
    always_comb begin
        if (beats_q < BW'(BURST_MAX)) begin
            burst_calc = 9'(beats_q);
        end else begin
            burst_calc = 9'(BURST_MAX);
        end
`ifdef AXIS_READ_ADDR_4K_SPLIT_EN
        // addr_q is beat aligned, so the division is exact.
        room_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> BEAT_SHIFT;
        if ({4'b0, burst_calc} > room_beats) begin
            burst_calc = 9'(room_beats);
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_d      = beats_q;
        burst_d      = burst_q;
        cfg_rdy_d    = cfg_rdy_q;
        len_val_d    = len_val_q;
        len_length_d = len_length_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_val) begin
                    addr_d       = job_addr;
                    beats_d      = job_beats;
                    len_length_d = cfg_length;
                    cfg_rdy_d    = 1'b0;
                    if (job_beats == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_LEN;
                        len_val_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                cfg_rdy_d = 1'b1;
            end
            S_LEN: begin
                if (len_rdy) begin
                    len_val_d = 1'b0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                burst_d   = burst_calc;
                arlen_d   = 8'(burst_calc - 9'd1);
                araddr_d  = addr_q;
                arvalid_d = 1'b1;
                state_d   = S_ADDR;
            end
            S_ADDR: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    addr_d    = addr_q + (AXI_ADDR_WIDTH'(burst_q) << BEAT_SHIFT);
                    beats_d   = beats_q - BW'(burst_q);
                    if (beats_q == BW'(burst_q)) begin
                        state_d   = S_IDLE;
                        cfg_rdy_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            beats_q      <= '0;
            burst_q      <= '0;
            cfg_rdy_q    <= 1'b1;
            len_val_q    <= 1'b0;
            len_length_q <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_q      <= beats_d;
            burst_q      <= burst_d;
            cfg_rdy_q    <= cfg_rdy_d;
            len_val_q    <= len_val_d;
            len_length_q <= len_length_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
        end
    end

    assign cfg_rdy     = cfg_rdy_q;
    assign len_val     = len_val_q;
    assign len_length  = len_length_q;
    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = araddr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = 3'(BEAT_SHIFT);
    assign axi_arburst = 2'b01;

endmodule
